note_packet_writer: RTL

NOTE_PACKET_WRITER -- requirements
Module: note_packet_writer

---
 rtl/note_packet_writer.sv | 94 +++++++++
 1 files changed

// File: rtl/note_packet_writer.sv
// note_packet_writer: queues note updates and writes them plus a priority score word over Avalon-MM during vblank.
module note_packet_writer #(
  parameter int          DEPTH      = 8,
  parameter logic [15:0] NOTE_ADDR  = 16'h6,
  parameter logic [15:0] SCORE_ADDR = 16'h4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_index,
  input  logic [5:0]  in_id,
  input  logic [9:0]  in_y,
  input  logic [9:0]  in_x,
  input  logic        score_valid,
  input  logic [15:0] score,
  input  logic [15:0] combo,
  input  logic        vblank,
  output logic [15:0] avm_address,
  output logic [31:0] avm_writedata,
  output logic        avm_write,
  output logic        avm_chipselect,
  input  logic        avm_waitrequest,
  output logic [6:0]  fifo_count,
  output logic [15:0] notes_sent
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state_q, state_d;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [6:0] count_q, count_d;
  logic [15:0] sent_q, sent_d, score_q, score_d, combo_q, combo_d, addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic pend_q, pend_d, is_score_q, is_score_d;
  logic push, pop, issue_score, done;
  always_comb begin
    in_ready    = count_q < 7'(DEPTH);
    push        = in_valid && in_ready;
    issue_score = state_q == IDLE && vblank && pend_q;
    pop         = state_q == IDLE && vblank && !pend_q && count_q != 7'd0;
    done        = state_q == WRITE && !avm_waitrequest;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb state_d = (issue_score || pop) ? WRITE : done ? IDLE : state_q;
  always_comb begin
    avm_write      = state_q == WRITE;
    avm_chipselect = state_q == WRITE;
    avm_address    = addr_q;
    avm_writedata  = data_q;
    fifo_count     = count_q;
    notes_sent     = sent_q;
  end
  always_comb begin
    wr_d       = wr_q + AW'(push);
    rd_d       = rd_q + AW'(pop);
    count_d    = count_q + 7'(push) - 7'(pop);
    sent_d     = sent_q + 16'(done && !is_score_q);
    score_d    = score_valid ? score : score_q;
    combo_d    = score_valid ? combo : combo_q;
    pend_d     = score_valid || (pend_q && !(done && is_score_q));
    is_score_d = issue_score ? 1'b1 : pop ? 1'b0 : is_score_q;
    addr_d     = issue_score ? SCORE_ADDR : pop ? NOTE_ADDR : addr_q;
    data_d     = issue_score ? {combo_q, score_q} : pop ? mem[rd_q] : data_q;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_q] <= {in_index, in_id, in_y, in_x};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      sent_q     <= '0;
      score_q    <= '0;
      combo_q    <= '0;
      pend_q     <= 1'b0;
      is_score_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      sent_q     <= sent_d;
      score_q    <= score_d;
      combo_q    <= combo_d;
      pend_q     <= pend_d;
      is_score_q <= is_score_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
endmodule
